// File: rtl/load_write_packer.sv
// Packs narrow loader beats into DATA_WIDTH words and issues them as
// sequential-address writes on the arbiter's load port; pulses done at the end.
module load_write_packer #(
    parameter int unsigned ROW_PARA   = 4,
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned IN_WIDTH   = 64,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_p,
    input  logic                  cmd_valid_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [ROW_PARA-1:0]   cmd_bank_en_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  cmd_ready_o,
    input  logic                  in_valid_i,
    input  logic [IN_WIDTH-1:0]   in_data_i,
    output logic                  in_ready_o,
    output logic                  load_write_valid_o,
    output logic [ROW_PARA-1:0]   load_write_bank_en_o,
    output logic [ADDR_WIDTH-1:0] load_write_addr_o,
    output logic [DATA_WIDTH-1:0] load_write_data_o,
    input  logic                  load_write_ready_i,
    output logic                  done_o
);
    localparam int unsigned RATIO   = DATA_WIDTH / IN_WIDTH;
    localparam int unsigned CNT_W   = $clog2(RATIO);
    localparam int unsigned BEATS_W = LEN_WIDTH + CNT_W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                r_state, w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ROW_PARA-1:0]   r_bank_en;
    logic [BEATS_W-1:0]    r_beats_rem;
    logic [LEN_WIDTH-1:0]  r_words_rem;
    logic [CNT_W-1:0]      r_pack_cnt;
    logic [DATA_WIDTH-1:0] r_pack;
    logic                  r_wr_valid;
    logic [ROW_PARA-1:0]   r_wr_bank_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic                  w_last_slot;
    logic                  w_in_ready;
    logic                  w_beat;
    logic                  w_complete;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_word;

    // The completing beat may enter only if the output register is free or draining this cycle.
    always_comb begin
        w_last_slot = (r_pack_cnt == CNT_W'(RATIO - 1));
        w_in_ready  = (r_state == RUN) && (r_beats_rem != '0) &&
                      (!w_last_slot || !r_wr_valid || load_write_ready_i);
        w_beat      = in_valid_i && w_in_ready;
        w_complete  = w_beat && w_last_slot;
        w_xfer      = r_wr_valid && load_write_ready_i;
        w_word      = r_pack;
        w_word[(RATIO-1)*IN_WIDTH +: IN_WIDTH] = in_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst_p) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (cmd_valid_i) w_next_state = (cmd_len_i == '0) ? DONE : RUN;
            RUN:  if (w_xfer && r_words_rem == LEN_WIDTH'(1)) w_next_state = DONE;
            DONE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o          = (r_state == IDLE);
        done_o               = (r_state == DONE);
        in_ready_o           = w_in_ready;
        load_write_valid_o   = r_wr_valid;
        load_write_bank_en_o = r_wr_bank_en;
        load_write_addr_o    = r_wr_addr;
        load_write_data_o    = r_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_addr       <= '0;
            r_bank_en    <= '0;
            r_beats_rem  <= '0;
            r_words_rem  <= '0;
            r_pack_cnt   <= '0;
            r_pack       <= '0;
            r_wr_valid   <= 1'b0;
            r_wr_bank_en <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            if (r_state == IDLE && cmd_valid_i) begin
                r_addr      <= cmd_addr_i;
                r_bank_en   <= cmd_bank_en_i;
                r_beats_rem <= BEATS_W'(cmd_len_i) * BEATS_W'(RATIO);
                r_words_rem <= cmd_len_i;
                r_pack_cnt  <= '0;
            end
            if (w_beat) begin
                r_beats_rem <= r_beats_rem - BEATS_W'(1);
                for (int unsigned k = 0; k < RATIO; k++) begin
                    if (r_pack_cnt == CNT_W'(k)) r_pack[k*IN_WIDTH +: IN_WIDTH] <= in_data_i;
                end
                r_pack_cnt <= w_last_slot ? '0 : r_pack_cnt + CNT_W'(1);
            end
            // A new word loading in the drain cycle keeps valid high.
            if (w_complete) begin
                r_wr_valid   <= 1'b1;
                r_wr_data    <= w_word;
                r_wr_addr    <= r_addr;
                r_wr_bank_en <= r_bank_en;
                r_addr       <= r_addr + ADDR_WIDTH'(1);
            end else if (w_xfer) begin
                r_wr_valid   <= 1'b0;
            end
            if (w_xfer) r_words_rem <= r_words_rem - LEN_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_load_write_packer.sv
// Directed bench for load_write_packer: expected writes are queued when a
// command is issued and compared whenever the DUT presents a write.
module tb_load_write_packer;
    logic         clk = 1'b0;
    logic         rst_p;
    logic         cmd_valid_i;
    logic [47:0]  cmd_addr_i;
    logic [3:0]   cmd_bank_en_i;
    logic [15:0]  cmd_len_i;
    logic         cmd_ready_o;
    logic         in_valid_i;
    logic [63:0]  in_data_i;
    logic         in_ready_o;
    logic         load_write_valid_o;
    logic [3:0]   load_write_bank_en_o;
    logic [47:0]  load_write_addr_o;
    logic [255:0] load_write_data_o;
    logic         load_write_ready_i;
    logic         done_o;

    typedef struct {
        logic [47:0]  addr;
        logic [3:0]   bank;
        logic [255:0] data;
    } wr_t;
    wr_t sb[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc = 0;
    int unsigned accept_cyc = 0;
    int unsigned last_xfer_cyc = 0;
    int unsigned xfer_in_cmd = 0;
    int unsigned held_acc = 0;
    int unsigned stall = 0;
    bit          bp_arm = 1'b0;
    bit          tp_mode = 1'b0;

    load_write_packer #(
        .ROW_PARA(4), .ADDR_WIDTH(48), .DATA_WIDTH(256), .IN_WIDTH(64), .LEN_WIDTH(16)
    ) dut (
        .clk(clk), .rst_p(rst_p),
        .cmd_valid_i(cmd_valid_i), .cmd_addr_i(cmd_addr_i), .cmd_bank_en_i(cmd_bank_en_i),
        .cmd_len_i(cmd_len_i), .cmd_ready_o(cmd_ready_o),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .load_write_valid_o(load_write_valid_o), .load_write_bank_en_o(load_write_bank_en_o),
        .load_write_addr_o(load_write_addr_o), .load_write_data_o(load_write_data_o),
        .load_write_ready_i(load_write_ready_i), .done_o(done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] word(input logic [63:0] base, input int unsigned i);
        logic [255:0] w;
        for (int k = 0; k < 4; k++) w[k*64 +: 64] = base + 64'(i*4 + k);
        return w;
    endfunction

    // Arbiter model: ready high unless a backpressure window is armed.
    always @(posedge clk) begin
        #1;
        if (bp_arm && load_write_valid_o) begin
            bp_arm = 1'b0;
            stall  = 10;
        end
        if (stall > 0) begin
            load_write_ready_i = 1'b0;
            stall--;
        end else begin
            load_write_ready_i = 1'b1;
        end
    end

    // Output monitor: held words must match the queue head every cycle.
    always @(negedge clk) begin
        if (!rst_p && load_write_valid_o) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", 256'(load_write_valid_o), 256'(0));
            end else begin
                chk("wr_addr", 256'(load_write_addr_o), 256'(sb[0].addr));
                chk("wr_bank", 256'(load_write_bank_en_o), 256'(sb[0].bank));
                chk("wr_data", load_write_data_o, sb[0].data);
                if (load_write_ready_i) begin
                    void'(sb.pop_front());
                    if (tp_mode) begin
                        if (xfer_in_cmd == 0) chk("tp_first", 256'(cyc), 256'(accept_cyc + 5));
                        else                  chk("tp_interval", 256'(cyc - last_xfer_cyc), 256'(4));
                    end
                    xfer_in_cmd++;
                    last_xfer_cyc = cyc;
                end
            end
        end
        if (!rst_p && load_write_valid_o && !load_write_ready_i && in_valid_i && in_ready_o)
            held_acc++;
    end

    task automatic send_cmd(input logic [47:0] addr, input logic [3:0] bank,
                            input int unsigned len, input logic [63:0] base, input bit push);
        bit  got = 1'b0;
        wr_t e;
        if (push) begin
            for (int unsigned i = 0; i < len; i++) begin
                e.addr = addr + 48'(i);
                e.bank = bank;
                e.data = word(base, i);
                sb.push_back(e);
            end
        end
        xfer_in_cmd   = 0;
        cmd_valid_i   = 1'b1;
        cmd_addr_i    = addr;
        cmd_bank_en_i = bank;
        cmd_len_i     = 16'(len);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                got = 1'b1;
                accept_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        cmd_valid_i = 1'b0;
        chk("cmd_accept", 256'(got), 256'(1));
    endtask

    task automatic send_beats(input logic [63:0] base, input int unsigned n, input bit junk);
        bit got;
        for (int unsigned j = 0; j < n; j++) begin
            in_valid_i = 1'b1;
            in_data_i  = base + 64'(j);
            got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge clk);
                got = in_ready_o;
                @(posedge clk); #1;
            end
            chk("beat_accept", 256'(got), 256'(1));
        end
        in_valid_i = junk;
        in_data_i  = 64'hDEAD_BEEF_0BAD_F00D;
    endtask

    task automatic wait_done(input bit zero_len);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            chk("in_ready_quiet", 256'(in_ready_o), 256'(0));
            if (done_o) begin
                found = 1'b1;
                chk("done_cyc", 256'(cyc), 256'(zero_len ? accept_cyc + 1 : last_xfer_cyc + 1));
            end
        end
        chk("done_seen", 256'(found), 256'(1));
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("done_pulse_end", 256'(done_o), 256'(0));
        chk("cmd_ready_back", 256'(cmd_ready_o), 256'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_p = 1'b1; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_bank_en_i = '0; cmd_len_i = '0;
        in_valid_i = 1'b0; in_data_i = '0; load_write_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_p = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 256'(cmd_ready_o), 256'(1));
        chk("rst_valid", 256'(load_write_valid_o), 256'(0));
        chk("rst_in_ready", 256'(in_ready_o), 256'(0));
        chk("rst_done", 256'(done_o), 256'(0));
        @(posedge clk); #1;

        // Basic pack, with an extra beat offered after the last one.
        send_cmd(48'h100, 4'b0011, 2, 64'h11, 1'b1);
        send_beats(64'h11, 8, 1'b1);
        wait_done(1'b0);

        // Output held for 10 cycles after the first word appears.
        held_acc = 0;
        bp_arm   = 1'b1;
        send_cmd(48'h100, 4'b0011, 2, 64'h11, 1'b1);
        send_beats(64'h11, 8, 1'b0);
        wait_done(1'b0);
        chk("bp_beats_while_held", 256'(held_acc), 256'(3));

        // Continuous streaming throughput.
        tp_mode = 1'b1;
        send_cmd(48'h400, 4'b1111, 8, 64'h1000, 1'b1);
        send_beats(64'h1000, 32, 1'b0);
        wait_done(1'b0);
        tp_mode = 1'b0;
        chk("tp_words", 256'(xfer_in_cmd), 256'(8));

        // Address wraps at the top of the address space.
        send_cmd(48'hFFFF_FFFF_FFFF, 4'b1000, 2, 64'h2000, 1'b1);
        send_beats(64'h2000, 8, 1'b0);
        wait_done(1'b0);

        // Zero-length command with input offered throughout.
        in_valid_i = 1'b1;
        in_data_i  = 64'hBAD0;
        send_cmd(48'h700, 4'b0001, 0, 64'h0, 1'b1);
        wait_done(1'b1);
        chk("zero_len_words", 256'(xfer_in_cmd), 256'(0));

        // Reset with a half-packed word, then a fresh single-word command.
        send_cmd(48'h300, 4'b0101, 1, 64'h50, 1'b0);
        send_beats(64'h50, 2, 1'b0);
        rst_p = 1'b1;
        @(posedge clk); #1;
        rst_p = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 256'(load_write_valid_o), 256'(0));
        chk("mid_rst_data", load_write_data_o, 256'(0));
        chk("mid_rst_addr", 256'(load_write_addr_o), 256'(0));
        chk("mid_rst_bank", 256'(load_write_bank_en_o), 256'(0));
        chk("mid_rst_done", 256'(done_o), 256'(0));
        chk("mid_rst_in_ready", 256'(in_ready_o), 256'(0));
        chk("mid_rst_cmd_ready", 256'(cmd_ready_o), 256'(1));
        @(posedge clk); #1;
        send_cmd(48'h500, 4'b0110, 1, 64'h60, 1'b1);
        send_beats(64'h60, 4, 1'b0);
        wait_done(1'b0);
        chk("post_rst_words", 256'(xfer_in_cmd), 256'(1));

        chk("sb_empty", 256'(sb.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
